// File: rtl/mux_rr.sv
// -----------------------------------------------------------------------------
// mux_rr
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
// A channel is chosen either by round-robin arbitration (mode = 0) or by
// manual selection through sel (mode = 1). The winning word goes into one
// output register. The block adds one cycle of latency and can accept a new
// word on every cycle.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    N*WIDTH input data; channel i occupies [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready; combinational, at most one bit high
//   mode       0 = round-robin, 1 = manual select
//   sel        channel index used when mode = 1
//   out_data   registered output data
//   out_chan   index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts the output word
// -----------------------------------------------------------------------------
module mux_rr #(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_chan;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   logic [WIDTH-1:0] w_chan_data [N];
   logic             w_space;
   logic             w_grant_vld;
   logic [SELW-1:0]  w_grant;
   logic [WIDTH-1:0] w_grant_data;
   logic             w_xfer;
   logic [SELW-1:0]  w_ptr_next;
   int               w_best;
   int               w_dist;

   // Unpack the flat data bus into one word per channel.
   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   assign w_space = !r_out_valid || out_ready;

   // Grant selection. In round-robin mode each valid channel gets a distance
   // from the pointer (wrapping modulo N) and the smallest distance wins.
   // In manual mode only the channel whose index equals sel can win, so an
   // out-of-range sel (N not a power of two) matches nothing.
   always_comb begin
      w_grant_vld  = 1'b0;
      w_grant      = '0;
      w_grant_data = '0;
      w_best       = N;
      w_dist       = 0;
      if (mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               w_grant_vld  = 1'b1;
               w_grant      = SELW'(i);
               w_grant_data = w_chan_data[i];
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
               w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N - int'(r_ptr));
               if (w_dist < w_best) begin
                  w_best       = w_dist;
                  w_grant_vld  = 1'b1;
                  w_grant      = SELW'(i);
                  w_grant_data = w_chan_data[i];
               end
            end
         end
      end
   end

   // rst_n gates the handshake so no channel sees ready while reset is held,
   // even though the emptied output register would otherwise report space.
   assign w_xfer = w_grant_vld && w_space && rst_n;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (w_xfer && w_grant == SELW'(i)) begin
            in_ready[i] = 1'b1;
         end
      end
   end

   assign w_ptr_next = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         // A load also covers the drain-and-refill case: the new word
         // replaces the one being consumed on this edge.
         r_out_data  <= w_grant_data;
         r_out_chan  <= w_grant;
         r_out_valid <= 1'b1;
         r_ptr       <= w_ptr_next;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr.sv
module tb_mux_rr;

   logic        clk;
   logic        rst_n;

   // N = 4 instance
   logic [31:0] in_data4;
   logic [3:0]  in_valid4;
   logic [3:0]  in_ready4;
   logic        mode4;
   logic [1:0]  sel4;
   logic [7:0]  out_data4;
   logic [1:0]  out_chan4;
   logic        out_valid4;
   logic        out_ready4;

   // N = 3 instance, used for the out-of-range select case
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic [1:0]  out_chan3;
   logic        out_valid3;
   logic        out_ready3;

   int total = 0;
   int bad   = 0;

   mux_rr #(.N(4), .WIDTH(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .sel(sel4),
      .out_data(out_data4), .out_chan(out_chan4), .out_valid(out_valid4),
      .out_ready(out_ready4)
   );

   mux_rr #(.N(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
      .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] valid;
      logic       mode;
      logic [1:0] sel;
      logic       oready;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_d;
      logic [1:0] exp_c;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic [3:0] v, input logic m, input logic [1:0] s,
                               input logic r, input logic [3:0] er, input logic eov,
                               input logic [7:0] ed, input logic [1:0] ec);
      vec_t t;
      t.valid = v; t.mode = m; t.sel = s; t.oready = r;
      t.exp_rdy = er; t.exp_ov = eov; t.exp_d = ed; t.exp_c = ec;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Channel i carries A0+i.
      in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid4  = '0;
      mode4      = 1'b0;
      sel4       = '0;
      out_ready4 = 1'b1;
      in_data3   = {8'hB2, 8'hB1, 8'hB0};
      in_valid3  = '0;
      mode3      = 1'b0;
      sel3       = '0;
      out_ready3 = 1'b1;
      rst_n      = 1'b0;

      //           valid  m  sel  rdy  exp_rdy ov  data   chan
      vecs[0]  = mk(4'hF, 0, 2'd0, 1, 4'b0001, 1, 8'hA0, 2'd0); // fairness
      vecs[1]  = mk(4'hF, 0, 2'd0, 1, 4'b0010, 1, 8'hA1, 2'd1);
      vecs[2]  = mk(4'hF, 0, 2'd0, 1, 4'b0100, 1, 8'hA2, 2'd2);
      vecs[3]  = mk(4'hF, 0, 2'd0, 1, 4'b1000, 1, 8'hA3, 2'd3);
      vecs[4]  = mk(4'hF, 0, 2'd0, 1, 4'b0001, 1, 8'hA0, 2'd0); // wrap
      vecs[5]  = mk(4'hF, 0, 2'd0, 1, 4'b0010, 1, 8'hA1, 2'd1); // ptr -> 2
      vecs[6]  = mk(4'hA, 0, 2'd0, 1, 4'b1000, 1, 8'hA3, 2'd3); // skip/wrap 3,1,3,1
      vecs[7]  = mk(4'hA, 0, 2'd0, 1, 4'b0010, 1, 8'hA1, 2'd1);
      vecs[8]  = mk(4'hA, 0, 2'd0, 1, 4'b1000, 1, 8'hA3, 2'd3);
      vecs[9]  = mk(4'hA, 0, 2'd0, 1, 4'b0010, 1, 8'hA1, 2'd1);
      vecs[10] = mk(4'hF, 1, 2'd2, 1, 4'b0100, 1, 8'hA2, 2'd2); // manual sel=2
      vecs[11] = mk(4'hF, 1, 2'd2, 1, 4'b0100, 1, 8'hA2, 2'd2);
      vecs[12] = mk(4'hF, 1, 2'd2, 1, 4'b0100, 1, 8'hA2, 2'd2);
      vecs[13] = mk(4'hF, 0, 2'd0, 1, 4'b1000, 1, 8'hA3, 2'd3); // back to RR -> 3
      vecs[14] = mk(4'h0, 0, 2'd0, 1, 4'b0000, 0, 8'hA3, 2'd3); // drain, hold data
      vecs[15] = mk(4'h1, 1, 2'd1, 1, 4'b0000, 0, 8'hA3, 2'd3); // sel not valid
      vecs[16] = mk(4'h1, 1, 2'd0, 0, 4'b0001, 1, 8'hA0, 2'd0); // empty reg => space
      vecs[17] = mk(4'hF, 0, 2'd0, 0, 4'b0000, 1, 8'hA0, 2'd0); // stall
      vecs[18] = mk(4'hF, 0, 2'd0, 1, 4'b0010, 1, 8'hA1, 2'd1); // resume from ptr 1

      // Reset state
      #3;
      check("reset_out_valid", 32'(out_valid4), 32'd0);
      check("reset_out_data",  32'(out_data4),  32'd0);
      check("reset_out_chan",  32'(out_chan4),  32'd0);
      in_valid4 = 4'hF;
      #1;
      check("reset_in_ready", 32'(in_ready4), 32'd0);
      in_valid4 = 4'h0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Table-driven vectors
      for (int i = 0; i < 19; i++) begin
         in_valid4  = vecs[i].valid;
         mode4      = vecs[i].mode;
         sel4       = vecs[i].sel;
         out_ready4 = vecs[i].oready;
         #1;
         check($sformatf("v%0d_in_ready", i), 32'(in_ready4), 32'(vecs[i].exp_rdy));
         tick();
         check($sformatf("v%0d_out_valid", i), 32'(out_valid4), 32'(vecs[i].exp_ov));
         check($sformatf("v%0d_out_data", i),  32'(out_data4),  32'(vecs[i].exp_d));
         check($sformatf("v%0d_out_chan", i),  32'(out_chan4),  32'(vecs[i].exp_c));
         $display("vec %0d: valid=%b mode=%0d sel=%0d ordy=%0d -> in_ready=%b ov=%0d data=%h chan=%0d",
                  i, vecs[i].valid, vecs[i].mode, vecs[i].sel, vecs[i].oready,
                  in_ready4, out_valid4, out_data4, out_chan4);
      end

      // Backpressure: ptr is 2 here. Load 5C from channel 2, then stall with
      // channel 3 (7E) pending; it must be delivered once out_ready returns.
      in_data4   = {8'h7E, 8'h5C, 8'hA1, 8'hA0};
      in_valid4  = 4'b0100;
      mode4      = 1'b0;
      out_ready4 = 1'b1;
      tick();
      check("bp_load_data", 32'(out_data4), 32'h5C);
      check("bp_load_chan", 32'(out_chan4), 32'd2);
      in_valid4  = 4'b1000;
      out_ready4 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp_stall%0d_in_ready", c), 32'(in_ready4), 32'd0);
         tick();
         check($sformatf("bp_stall%0d_data", c),  32'(out_data4),  32'h5C);
         check($sformatf("bp_stall%0d_valid", c), 32'(out_valid4), 32'd1);
         $display("bp stall %0d: data=%h valid=%0d in_ready=%b", c, out_data4, out_valid4, in_ready4);
      end
      out_ready4 = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready4), 32'b1000);
      tick();
      check("bp_release_data", 32'(out_data4), 32'h7E);
      check("bp_release_chan", 32'(out_chan4), 32'd3);
      $display("bp release: data=%h chan=%0d", out_data4, out_chan4);

      // Reset mid-stream with a word held in the output register.
      in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid4  = 4'hF;
      out_ready4 = 1'b0;
      tick();
      check("mid_pre_valid", 32'(out_valid4), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",    32'(out_valid4), 32'd0);
      check("mid_rst_data",     32'(out_data4),  32'd0);
      check("mid_rst_chan",     32'(out_chan4),  32'd0);
      check("mid_rst_in_ready", 32'(in_ready4),  32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready4 = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready4), 32'b0001);
      tick();
      check("post_rst_data", 32'(out_data4), 32'hA0);
      check("post_rst_chan", 32'(out_chan4), 32'd0);
      $display("reset mid-stream: first word after reset data=%h chan=%0d", out_data4, out_chan4);

      // N = 3, manual select out of range.
      in_valid3  = 3'b111;
      mode3      = 1'b1;
      sel3       = 2'd0;
      out_ready3 = 1'b1;
      tick();
      check("n3_load_valid", 32'(out_valid3), 32'd1);
      check("n3_load_data",  32'(out_data3),  32'hB0);
      sel3 = 2'd3;
      #1;
      check("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
      tick();
      check("n3_sel3_drain", 32'(out_valid3), 32'd0);
      check("n3_sel3_data_held", 32'(out_data3), 32'hB0);
      $display("n3 sel=3: in_ready=%b out_valid=%0d", in_ready3, out_valid3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
